// File: rtl/tankwar_pkg.sv
// Shared tank-war definitions: tile codes, palette, field geometry and the
// tile-map write FSM states.
package tankwar_pkg;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_BRICK = 2'd1,
    TILE_STEEL = 2'd2,
    TILE_WATER = 2'd3
  } tile_e;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_HOLD  = 2'd2
  } wr_state_e;

  localparam int TILE_SHIFT      = 5;
  localparam int FIELD_SIZE      = 512;
  localparam int FRAME_LATCH_ROW = 480;

  localparam logic [11:0] COL_EMPTY  = 12'h000;
  localparam logic [11:0] COL_BRICK  = 12'h04C;
  localparam logic [11:0] COL_MORTAR = 12'h777;
  localparam logic [11:0] COL_STEEL  = 12'hAAA;
  localparam logic [11:0] COL_WATER  = 12'hE52;
  localparam logic [11:0] COL_TANK0  = 12'h0FF;
  localparam logic [11:0] COL_TANK1  = 12'h0F0;

  // Bricks get a mortar line on every eighth row.
  function automatic logic [11:0] tile_colour(input tile_e t, input logic [2:0] row_lsb);
    case (t)
      TILE_BRICK: return (row_lsb == 3'd0) ? COL_MORTAR : COL_BRICK;
      TILE_STEEL: return COL_STEEL;
      TILE_WATER: return COL_WATER;
      default:    return COL_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/tile_map_ram.sv
// 256 x 2-bit tile map: registered read port plus an independent write port.
module tile_map_ram
  import tankwar_pkg::*;
(
  input  logic       vga_clk,
  input  logic       wr_en_i,
  input  logic [7:0] wr_addr_i,
  input  tile_e      wr_data_i,
  input  logic [7:0] rd_addr_i,
  output tile_e      rd_data_o
);

  tile_e mem_q [256];

  // Contents are established by the owner's clear sweep, not by reset.
  always_ff @(posedge vga_clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/tile_renderer.sv
// Renders the 16x16 tile map plus two tank sprites into the VGA pixel stream,
// and serialises tile-map updates into the vertical blanking window.
module tile_renderer
  import tankwar_pkg::*;
#(
  parameter int LOOKAHEAD = 2
) (
  input  logic            vga_clk,
  input  logic            clrn,
  input  logic [9:0]      row_addr,
  input  logic [9:0]      col_addr,
  input  logic            rdn,
  output logic [11:0]     pixel,
  input  logic            map_wr_valid,
  output logic            map_wr_ready,
  input  logic [7:0]      map_wr_addr,
  input  logic [1:0]      map_wr_tile,
  input  logic [1:0][8:0] tank_x,
  input  logic [1:0][8:0] tank_y,
  input  logic [1:0]      tank_en
);

  localparam logic [9:0] LATCH_ROW = 10'(FRAME_LATCH_ROW);
  localparam logic [9:0] FIELD_LIM = 10'(FIELD_SIZE);

  logic rdn_unused;
  assign rdn_unused = rdn;

  // Stage 1: lookup coordinates and the tile RAM read.
  logic [9:0] look_c;
  logic [9:0] r_q, c_q;
  logic       vld_q;
  tile_e      tile_rd;

  assign look_c = col_addr + 10'(LOOKAHEAD);

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_q   <= '0;
      c_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      r_q   <= row_addr;
      c_q   <= look_c;
      vld_q <= 1'b1;
    end
  end

  // Per-frame tank shadow; r_q holds the previous row, so this fires on entry to 480.
  logic            latch_frame;
  logic [1:0]      sh_en_q;
  logic [1:0][8:0] sh_x_q, sh_y_q;

  assign latch_frame = (row_addr == LATCH_ROW) && (r_q != LATCH_ROW);

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      sh_en_q <= '0;
      sh_x_q  <= '0;
      sh_y_q  <= '0;
    end else if (latch_frame) begin
      sh_en_q <= tank_en;
      sh_x_q  <= tank_x;
      sh_y_q  <= tank_y;
    end
  end

  logic [1:0] hit;
  for (genvar gi = 0; gi < 2; gi++) begin : g_tank
    logic [9:0] tx, ty;
    assign tx      = {1'b0, sh_x_q[gi]};
    assign ty      = {1'b0, sh_y_q[gi]};
    assign hit[gi] = sh_en_q[gi] && (c_q >= tx) && (c_q <= tx + 10'd31)
                                 && (r_q >= ty) && (r_q <= ty + 10'd31);
  end

  // Stage 2: colour selection.
  logic [11:0] pixel_d;

  always_comb begin
    pixel_d = COL_EMPTY;
    if (!vld_q || (r_q >= FIELD_LIM) || (c_q >= FIELD_LIM)) begin
      pixel_d = COL_EMPTY;
    end else if (hit[0]) begin
      pixel_d = COL_TANK0;
    end else if (hit[1]) begin
      pixel_d = COL_TANK1;
    end else begin
      pixel_d = tile_colour(tile_rd, r_q[2:0]);
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      pixel <= '0;
    end else begin
      pixel <= pixel_d;
    end
  end

  // Write FSM: clear sweep, then one buffered write committed in blanking.
  wr_state_e  state_q, state_d;
  logic [7:0] clr_cnt_q, clr_cnt_d;
  logic [7:0] buf_addr_q, buf_addr_d;
  tile_e      buf_tile_q, buf_tile_d;
  logic       wr_en;
  logic [7:0] wr_addr;
  tile_e      wr_data;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      buf_addr_q <= '0;
      buf_tile_q <= TILE_EMPTY;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      buf_addr_q <= buf_addr_d;
      buf_tile_q <= buf_tile_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    buf_addr_d   = buf_addr_q;
    buf_tile_d   = buf_tile_q;
    map_wr_ready = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = buf_addr_q;
    wr_data      = buf_tile_q;
    case (state_q)
      ST_CLEAR: begin
        wr_en     = 1'b1;
        wr_addr   = clr_cnt_q;
        wr_data   = TILE_EMPTY;
        clr_cnt_d = clr_cnt_q + 8'd1;
        if (clr_cnt_q == 8'hFF) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        map_wr_ready = 1'b1;
        if (map_wr_valid) begin
          buf_addr_d = map_wr_addr;
          buf_tile_d = tile_e'(map_wr_tile);
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (row_addr >= LATCH_ROW) begin
          wr_en   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  tile_map_ram u_map (
    .vga_clk   (vga_clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i ({row_addr[TILE_SHIFT+3:TILE_SHIFT], look_c[TILE_SHIFT+3:TILE_SHIFT]}),
    .rd_data_o (tile_rd)
  );

endmodule

// File: doc/tile_renderer.md
TILE_RENDERER -- requirements
Module: tile_renderer

Interface
REQ-001 Parameter: LOOKAHEAD, default 2, pipeline depth in pixels; the address is pre-advanced by this amount.
REQ-002 vga_clk  in  1  pixel clock, 25 MHz; all logic on its rising edge.
REQ-003 clrn  in  1  reset, asynchronous, active-low.
REQ-004 row_addr  in  10  registered row from the VGA controller.
REQ-005 col_addr  in  10  registered column from the VGA controller.
REQ-006 rdn  in  1  active-low read strobe from the VGA controller; informational only.
REQ-007 pixel  out  12  bbbb_gggg_rrrr colour; drives the controller's pixel input.
REQ-008 map_wr_valid  in  1  tile write request.
REQ-009 map_wr_ready  out  1  tile write accepted when valid&&ready.
REQ-010 map_wr_addr  in  8  tile index, {tile_row[3:0], tile_col[3:0]}.
REQ-011 map_wr_tile  in  2  tile code: 0 empty, 1 brick, 2 steel, 3 water.
REQ-012 tank_x  in  2x9  tank top-left column, per tank.
REQ-013 tank_y  in  2x9  tank top-left row, per tank.
REQ-014 tank_en  in  2  tank visible, per tank.

Function
REQ-015 The play field SHALL be 512x512 pixels, organised as 16x16 tiles of 32x32 pixels; tile index = {r[8:5], c[8:5]}.
REQ-016 Lookup coordinates SHALL be r = row_addr and c = col_addr + LOOKAHEAD (10-bit, wrapping).
REQ-017 pixel SHALL be registered with exactly LOOKAHEAD cycles of latency: stage 1 registers r, c and the tile RAM read; stage 2 registers the colour.
REQ-018 As a result, while col_addr = N, pixel SHALL hold the colour for (row_addr, N).
REQ-019 If r >= 512 or c >= 512, pixel SHALL be 12'h000.
REQ-020 Tile colours SHALL be: empty 12'h000; brick 12'h04C, except 12'h777 where r[2:0]==0; steel 12'hAAA; water 12'hE52.
REQ-021 A tank SHALL hit when tank_en[i] && tx <= c <= tx+31 && ty <= r <= ty+31, using 10-bit compares with no wrap; tanks extending past 511 are clipped.
REQ-022 Hit colours SHALL be tank0 12'h0FF and tank1 12'h0F0; priority SHALL be tank0 > tank1 > tile.
REQ-023 Tank inputs SHALL be shadow-latched once per frame, on the cycle row_addr changes to 480; hits use the shadow copy only.
REQ-024 Write FSM states: CLEAR, IDLE, HOLD.
REQ-025 CLEAR: write tile 0 to index clr_cnt, 0..255, one per cycle; map_wr_ready = 0; after index 255, go to IDLE.
REQ-026 IDLE: map_wr_ready = 1; on valid&&ready, capture addr/tile into a one-entry buffer and go to HOLD.
REQ-027 HOLD: map_wr_ready = 0; commit the buffer to RAM on the first cycle with row_addr >= 480 (unsigned), then go to IDLE.
REQ-028 This gives at most one write per 2 cycles, and no RAM writes while row_addr < 480.
REQ-029 While row_addr < 480, the frame shown SHALL be unaffected by any pending write.
REQ-030 map_wr_addr/map_wr_tile SHALL be ignored unless valid&&ready; valid held while ready is low SHALL be accepted on the first ready cycle.

Reset
REQ-031 On clrn low, the following SHALL be reset: pixel = 0, FSM = CLEAR, clr_cnt = 0, buffer empty, shadow tank_en = 0, shadow positions = 0, pipeline registers = 0.
REQ-032 During reset and CLEAR, map_wr_ready SHALL be 0.
REQ-033 A reset asserted in HOLD SHALL drop the pending write; the map is then cleared again.
REQ-034 Tile RAM contents SHALL not be reset directly; CLEAR establishes them.

Structure
REQ-035 Shared package tankwar_pkg SHALL hold: tile code enum, colour constants, TILE_SHIFT=5, FIELD_SIZE=512, FRAME_LATCH_ROW=480, FSM state typedef.
REQ-036 One sub-module, tile_map_ram: 256x2, synchronous read port plus independent write port, no reset.

Verification
REQ-037 Reset, then release -> pixel 0; map_wr_ready 0 for 256 cycles, then 1; the whole next frame is 12'h000.
REQ-038 Write addr 8'h11 tile 1 while row_addr = 100 -> ready stays 0 until row_addr = 480; RAM is written in that cycle.
REQ-039 Follow-on check for REQ-038: next frame, rows 32..63 / cols 32..63 show 12'h04C, with 12'h777 on rows 32, 40, 48, 56.
REQ-040 tank_x[0]=100, tank_y[0]=200, tank_en=2'b01 -> next frame, (200,100) = 12'h0FF, (200,99) = tile colour, (200,131) = 12'h0FF, (200,132) = tile colour.
REQ-041 Both tanks at (64,64), tank_en=2'b11 -> 12'h0FF in the overlap; changing positions mid-frame has no effect until row_addr reaches 480.
REQ-042 Tile 2 at 8'hFF; pulse clrn while a write is in HOLD -> pending write lost; rows 480..511 are 0 in the output; cols 480..511 show 12'hAAA only after a re-issued write; col_addr 520 -> 12'h000.
